// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl
//   Command sequencer in front of the shared NTT/INTT address generator.
//   Takes one NTT/INTT command, latches mode, VL and twiddle item, then steps
//   the shared cycle counter over every butterfly cycle of every stage.
//   The address generator returns the total cycle count (i_std_cnt) one cycle
//   after the command is latched; it is sampled at the end of LOAD.
//
//   Handshake: a command is transferred on a rising clock edge where
//   i_start=1 and o_ready=1. o_ready is high only in IDLE; i_start in any
//   other state is ignored and the latched fields are left untouched.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start/o_ready command handshake
//   i_ntt_mode      1=NTT, 0=INTT
//   i_vl            vector length in bits
//   i_tf_item_id    twiddle item select
//   i_std_cnt       total butterfly cycles from the address generator
//   o_ntt_mode, o_vl, o_tf_item_id   latched command fields
//   o_cnt           shared cycle counter
//   o_idle          address generator idle indication
//   o_rd_en         read / butterfly issue strobe
//   o_wr_en         o_rd_en delayed by PIPE_LAT cycles
//   o_done          one-cycle completion pulse
//   o_dbg_state     current FSM state (debug observation)
module ntt_seq_ctrl #(
    parameter int NLANE       = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TF_ITEM_NUM = 3,
    parameter int VLMAX       = 65536,
    parameter int PIPE_LAT    = 8,
    parameter int STAGE_GAP   = 0,
    localparam int STAGE_CYC  = VLMAX / DATA_WIDTH / 2 / (NLANE / 2),
    localparam int NTT_LOGN   = $clog2(VLMAX / DATA_WIDTH),
    localparam int CNT_WIDTH  = $clog2(NTT_LOGN) + $clog2(STAGE_CYC),
    localparam int TF_W       = $clog2(TF_ITEM_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    output logic                  o_ready,
    input  logic                  i_ntt_mode,
    input  logic [DATA_WIDTH-1:0] i_vl,
    input  logic [TF_W-1:0]       i_tf_item_id,
    input  logic [CNT_WIDTH:0]    i_std_cnt,
    output logic                  o_ntt_mode,
    output logic [DATA_WIDTH-1:0] o_vl,
    output logic [TF_W-1:0]       o_tf_item_id,
    output logic [CNT_WIDTH-1:0]  o_cnt,
    output logic                  o_idle,
    output logic                  o_rd_en,
    output logic                  o_wr_en,
    output logic                  o_done,
    output logic [2:0]            o_dbg_state
);

    // stage_cyc = vl >> SHIFT; only the low CNT_WIDTH bits matter for the mask
    localparam int SHIFT = $clog2(DATA_WIDTH) + 1 + $clog2(NLANE / 2);
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((STAGE_GAP > 1) ? STAGE_GAP - 1 : 0);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   ntt_mode_q, ntt_mode_d;
    logic [DATA_WIDTH-1:0]  vl_q, vl_d;
    logic [TF_W-1:0]        tf_item_q, tf_item_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   idle_q, idle_d;
    logic                   rd_en_q, rd_en_d;
    logic                   done_q, done_d;
    logic [PIPE_LAT-1:0]    wr_sr_q, wr_sr_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [DRN_W-1:0]       drn_cnt_q, drn_cnt_d;

    logic [CNT_WIDTH-1:0]   stage_mask;
    logic                   last_cyc;
    logic                   stage_end;

    assign stage_mask = vl_q[SHIFT +: CNT_WIDTH] - CNT_WIDTH'(1);
    // Compare is one bit wider than the counter so a full-range total never wraps
    assign last_cyc   = ({1'b0, cnt_q} == (i_std_cnt - (CNT_WIDTH + 1)'(1)));
    assign stage_end  = ((cnt_q & stage_mask) == stage_mask);

    // Write strobe pipeline: runs in every state so in-flight writes keep
    // retiring through DRAIN; only reset clears it.
    generate
        if (PIPE_LAT == 1) begin : g_wr_one
            assign wr_sr_d = rd_en_q;
        end else begin : g_wr_many
            assign wr_sr_d = {wr_sr_q[PIPE_LAT-2:0], rd_en_q};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        ntt_mode_d = ntt_mode_q;
        vl_d       = vl_q;
        tf_item_d  = tf_item_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        rd_en_d    = rd_en_q;
        done_d     = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        drn_cnt_d  = drn_cnt_q;

        case (state_q)
            S_IDLE: begin
                rd_en_d = 1'b0;
                idle_d  = 1'b1;
                if (i_start) begin
                    ntt_mode_d = i_ntt_mode;
                    vl_d       = i_vl;
                    tf_item_d  = i_tf_item_id;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                if (i_std_cnt == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    idle_d  = 1'b1;
                    rd_en_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                    idle_d  = 1'b0;
                    rd_en_d = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_cyc) begin
                    state_d   = S_DRAIN;
                    cnt_d     = '0;
                    rd_en_d   = 1'b0;
                    idle_d    = 1'b1;
                    drn_cnt_d = DRN_LAST;
                end else if ((STAGE_GAP > 0) && stage_end) begin
                    state_d   = S_GAP;
                    rd_en_d   = 1'b0;
                    gap_cnt_d = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_RUN;
                    rd_en_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drn_cnt_d = drn_cnt_q - DRN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rd_en_d = 1'b0;
                idle_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ntt_mode_q <= 1'b0;
            vl_q       <= '0;
            tf_item_q  <= '0;
            cnt_q      <= '0;
            idle_q     <= 1'b1;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_sr_q    <= '0;
            gap_cnt_q  <= '0;
            drn_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ntt_mode_q <= ntt_mode_d;
            vl_q       <= vl_d;
            tf_item_q  <= tf_item_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            wr_sr_q    <= wr_sr_d;
            gap_cnt_q  <= gap_cnt_d;
            drn_cnt_q  <= drn_cnt_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_ntt_mode   = ntt_mode_q;
    assign o_vl         = vl_q;
    assign o_tf_item_id = tf_item_q;
    assign o_cnt        = cnt_q;
    assign o_idle       = idle_q;
    assign o_rd_en      = rd_en_q;
    assign o_wr_en      = wr_sr_q[PIPE_LAT-1];
    assign o_done       = done_q;
    assign o_dbg_state  = state_q;

endmodule
